bus_led_stretcher: RTL and testbench
====================================

// Module: bus_led_stretcher
// PURPOSE
//   Output-side companion to input debouncing: takes N short event pulses and stretches each
//   to a fixed, human-visible duration on its LED output. Debouncing drops short glitches;
//   this block makes short events last. Sits between core logic and board LED pins.
//   Instantiates one led_stretcher per bit.
// PARAMETERS
//   N            1          number of independent channels
//   HOLD_CYCLES  1000000    output high time per accepted event, in clk cycles (>= 1)
//   CW           $clog2(HOLD_CYCLES+1)  counter width, derived; do not override
// PORTS
//   clk            input   1  system clock
//   rst            input   1  reset, asynchronous, active-low (0 = in reset)
//   pulse_in       input   N  event inputs, synchronous to clk, any pulse width >= 1 cycle
//   stretched_out  output  N  registered stretched outputs, one per channel
//   any_active     output  1  |stretched_out, combinational OR of registered outputs
// BEHAVIOUR
//   - Per channel: pulse_q <= pulse_in each cycle; trigger = pulse_in & ~pulse_q (rising edge).
//   - Reset (rst=0, async): state=IDLE, cnt=0, pulse_q=0, stretched_out=0, any_active=0.
//     Reset mid-HOLD drops the output immediately, with no completion.
//   - First cycle after reset release with pulse_in already 1 counts as a trigger (pulse_q=0).
//   - States: IDLE (out=0), HOLD (out=1).
//     IDLE: trigger -> HOLD, cnt <= HOLD_CYCLES-1, out <= 1. Otherwise stay IDLE.
//     HOLD: cnt != 0 -> cnt <= cnt-1, stay HOLD.
//           cnt == 0 -> IDLE, out <= 0 (see retrigger rules under CONFIGURATION).
//   - Latency: trigger sampled at edge k -> out high from edge k+1 (1 cycle).
//   - Single accepted trigger -> out high for exactly HOLD_CYCLES cycles.
//   - HOLD_CYCLES=1: out high 1 cycle; cnt loads 0.
//   - Input held high indefinitely: one trigger only; the stretch runs HOLD_CYCLES, then ends.
//   - Channels are fully independent; simultaneous triggers on all bits are legal.
//   - cnt never wraps: it decrements only in HOLD with cnt != 0.
// CONFIGURATION
//   Macro LED_STRETCH_RETRIGGER_EN:
//   - Defined: a trigger in HOLD, including the cnt==0 cycle, reloads cnt <= HOLD_CYCLES-1
//     and stays in HOLD. Out stays high until HOLD_CYCLES cycles after the last trigger.
//   - Undefined: triggers in HOLD are ignored and discarded, not queued. After expiry, out is
//     low for at least 1 cycle before the next accepted trigger raises it again.
// STRUCTURE
//   - Package bus_led_stretcher_pkg: typedef enum logic {STR_IDLE, STR_HOLD} stretch_state_t.
//   - Sub-module led_stretcher (params HOLD_CYCLES, CW; ports clk, rst, pulse_in,
//     stretched_out): 1-bit FSM, counter and edge register.
//   - Top: generate loop over N; any_active = |stretched_out.
// TESTING (N=2, HOLD_CYCLES=4)
//   1. rst=0 for 3 cycles, release with pulse_in=0 -> stretched_out=2'b00, any_active=0 throughout.
//   2. pulse_in[0]=1 for 1 cycle at edge k -> out[0]=1 for edges k+1..k+4, then 0;
//      out[1]=0 throughout.
//   3. pulse_in[1] held high 20 cycles -> out[1] high exactly 4 cycles after the first edge,
//      then low while input stays high.
//   4. Pulses on bit0 at k and k+2:
//      RETRIGGER_EN -> out[0] high k+1..k+6.
//      Without the macro -> out[0] high k+1..k+4 only.
//   5. Trigger on bit0 at k, rst=0 asserted mid-cycle at k+2 -> out[0]=0 immediately
//      (asynchronous, before next edge); after release, idle.
//   6. Release reset with pulse_in=2'b11 already high -> both outputs high 4 cycles starting one
//      edge after release; any_active mirrors the OR of the outputs.

Source files
------------

// File: rtl/bus_led_stretcher_pkg.sv
// Shared types for the LED pulse stretcher.
// The optional macro LED_STRETCH_RETRIGGER_EN is consumed by led_stretcher.
package bus_led_stretcher_pkg;

  typedef enum logic {STR_IDLE, STR_HOLD} stretch_state_t;

endpackage

// File: rtl/led_stretcher.sv
// Single-channel stretcher: a rising edge on pulse_in holds stretched_out high for HOLD_CYCLES.
// Define LED_STRETCH_RETRIGGER_EN to let edges during a hold restart the hold time.
module led_stretcher
  import bus_led_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000000,
  parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic stretched_out
);

  localparam logic [CW-1:0] LOAD_VALUE = CW'(HOLD_CYCLES - 1);

  stretch_state_t  r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_pulse_q;
  logic            r_out;
  logic            w_trigger;

  assign w_trigger     = pulse_in & ~r_pulse_q;
  assign stretched_out = r_out;

  // The counter holds the remaining high cycles minus one, so a load of zero still gives one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= STR_IDLE;
      r_cnt     <= '0;
      r_pulse_q <= 1'b0;
      r_out     <= 1'b0;
    end else begin
      r_pulse_q <= pulse_in;
      case (r_state)
        STR_IDLE: begin
          if (w_trigger) begin
            r_state <= STR_HOLD;
            r_cnt   <= LOAD_VALUE;
            r_out   <= 1'b1;
          end
        end
        STR_HOLD: begin
`ifdef LED_STRETCH_RETRIGGER_EN
          if (w_trigger) begin
            r_cnt <= LOAD_VALUE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= STR_IDLE;
            r_out   <= 1'b0;
          end
`else
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= STR_IDLE;
            r_out   <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_led_stretcher.sv
// N independent LED stretchers plus a combined activity flag.
// Retrigger behaviour follows the LED_STRETCH_RETRIGGER_EN macro inside led_stretcher.
module bus_led_stretcher
  import bus_led_stretcher_pkg::*;
#(
  parameter int N           = 1,
  parameter int HOLD_CYCLES = 1000000,
  parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pulse_in,
  output logic [N-1:0] stretched_out,
  output logic         any_active
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      led_stretcher #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CW          (CW)
      ) u_stretcher (
        .clk           (clk),
        .rst           (rst),
        .pulse_in      (pulse_in[gi]),
        .stretched_out (stretched_out[gi])
      );
    end
  endgenerate

  assign any_active = |stretched_out;

endmodule

// File: tb/tb_bus_led_stretcher.sv
// Scoreboard bench for bus_led_stretcher (N=2, HOLD_CYCLES=4), directed cases then random traffic.
// The reference model tracks remaining high cycles per channel; it honours LED_STRETCH_RETRIGGER_EN.
module tb_bus_led_stretcher;

  localparam int N = 2;
  localparam int H = 4;

  typedef struct packed {
    logic [N-1:0] outs;
    logic         any;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pulse_in;
  logic [N-1:0] stretched_out;
  logic         any_active;

  exp_t         expQ[$];
  int           checkCount = 0;
  int           errorCount = 0;
  int           remaining[N];
  logic [N-1:0] prevIn;

  bus_led_stretcher #(
    .N           (N),
    .HOLD_CYCLES (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pulse_in      (pulse_in),
    .stretched_out (stretched_out),
    .any_active    (any_active)
  );

  always #5 clk = ~clk;

  // Model of one clock edge: a fresh rising edge starts a stretch of H cycles.
  function automatic void modelEdge(input logic rstVal, input logic [N-1:0] pin);
    for (int ch = 0; ch < N; ch++) begin
      if (!rstVal) begin
        remaining[ch] = 0;
      end else begin
        logic trig;
        trig = pin[ch] & ~prevIn[ch];
        if (remaining[ch] == 0) begin
          if (trig) remaining[ch] = H;
        end else begin
`ifdef LED_STRETCH_RETRIGGER_EN
          if (trig) remaining[ch] = H;
          else      remaining[ch] = remaining[ch] - 1;
`else
          remaining[ch] = remaining[ch] - 1;
`endif
        end
      end
    end
    prevIn = rstVal ? pin : '0;
  endfunction

  function automatic exp_t modelOutput();
    exp_t e;
    for (int ch = 0; ch < N; ch++) e.outs[ch] = (remaining[ch] > 0);
    e.any = 1'b0;
    for (int ch = 0; ch < N; ch++) if (remaining[ch] > 0) e.any = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [N-1:0] actOut, input logic actAny,
                             input logic [N-1:0] expOut, input logic expAny);
    checkCount++;
    if (actOut !== expOut || actAny !== expAny) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: stretched_out=%b any_active=%b, expected %b %b",
               name, $time, actOut, actAny, expOut, expAny);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic [N-1:0] pin);
    @(negedge clk);
    rst      = rstVal;
    pulse_in = pin;
    modelEdge(rstVal, pin);
    expQ.push_back(modelOutput());
  endtask

  // Reset asserted mid-cycle must clear outputs before the next clock edge.
  task automatic asyncResetCheck();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncReset", stretched_out, any_active, '0, 1'b0);
    modelEdge(1'b0, pulse_in);
    expQ.push_back(modelOutput());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("scoreboard", stretched_out, any_active, e.outs, e.any);
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] p;
    int           drain;
    for (int ch = 0; ch < N; ch++) remaining[ch] = 0;
    prevIn   = '0;
    pulse_in = '0;
    rst      = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("resetState", stretched_out, any_active, '0, 1'b0);

    repeat (3) applyStimulus(1'b0, 2'b00);
    repeat (3) applyStimulus(1'b1, 2'b00);

    applyStimulus(1'b1, 2'b01);
    repeat (6) applyStimulus(1'b1, 2'b00);

    repeat (20) applyStimulus(1'b1, 2'b10);
    repeat (2) applyStimulus(1'b1, 2'b00);

    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b1, 2'b01);
    repeat (8) applyStimulus(1'b1, 2'b00);

    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b1, 2'b00);
    asyncResetCheck();
    repeat (2) applyStimulus(1'b0, 2'b00);
    repeat (3) applyStimulus(1'b1, 2'b00);

    repeat (2) applyStimulus(1'b0, 2'b11);
    repeat (6) applyStimulus(1'b1, 2'b11);
    repeat (2) applyStimulus(1'b1, 2'b00);

    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < N; ch++) p[ch] = ($urandom_range(0, 9) < 3);
      applyStimulus($urandom_range(0, 99) != 0, p);
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #5;
    if (expQ.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
